prefix_add_arbiter: RTL and testbench

- Shares one pipelined WIDTH-bit prefix adder between two requesters.
- Round-robin grant: at most one operation is issued per cycle into the adder.
- Each in-flight operation carries a requester tag down a shift register matched to the adder latency, so every result is steered back to the requester that issued it.
- Sits between the requesting units and the pipelined prefix adder instance.

---
 rtl/prefix_add_arbiter.sv | 106 ++++++++++
 tb/tb_prefix_add_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/prefix_add_arbiter.sv
// Round-robin arbiter that shares one pipelined prefix adder between two requesters.
// Each issue carries a requester tag alongside the adder pipeline, so the result returns to the requester that issued it.
module prefix_add_arbiter #(
  parameter int WIDTH = 32,
  parameter int LAT   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic [WIDTH-1:0]          req0_x,
  input  logic [WIDTH-1:0]          req0_y,
  input  logic                      req0_c,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic [WIDTH-1:0]          req1_x,
  input  logic [WIDTH-1:0]          req1_y,
  input  logic                      req1_c,
  output logic [WIDTH-1:0]          add_x,
  output logic [WIDTH-1:0]          add_y,
  output logic                      add_c,
  input  logic [WIDTH-1:0]          add_s,
  input  logic                      add_cout,
  output logic                      rsp0_valid,
  output logic [WIDTH-1:0]          rsp0_s,
  output logic                      rsp0_cout,
  output logic                      rsp1_valid,
  output logic [WIDTH-1:0]          rsp1_s,
  output logic                      rsp1_cout,
  output logic [$clog2(LAT+2)-1:0]  inflight,
  output logic                      idle
);
  localparam int CW = $clog2(LAT+2);

  logic          r_ptr;
  logic [LAT:0]  r_tag_vld;
  logic [LAT:0]  r_tag_id;
  logic [CW-1:0] r_inflight;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_issue;
  logic          w_emit;

  // Pointer names the requester that wins when both are valid.
  always_comb begin
    w_gnt0 = en & req0_valid & (~req1_valid | ~r_ptr);
    w_gnt1 = en & req1_valid & (~req0_valid |  r_ptr);
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign w_issue    = w_gnt0 | w_gnt1;
  assign w_emit     = r_tag_vld[LAT];
  assign inflight   = r_inflight;
  assign idle       = (r_inflight == '0);

  // Stage 0 is loaded together with add_*; stage LAT lines up with add_s/add_cout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= 1'b0;
      r_tag_vld  <= '0;
      r_tag_id   <= '0;
      r_inflight <= '0;
      add_x      <= '0;
      add_y      <= '0;
      add_c      <= 1'b0;
    end else begin
      r_tag_vld <= {r_tag_vld[LAT-1:0], w_issue};
      r_tag_id  <= {r_tag_id[LAT-1:0], w_gnt1};
      if (w_issue) begin
        r_ptr <= w_gnt0;
        add_x <= w_gnt1 ? req1_x : req0_x;
        add_y <= w_gnt1 ? req1_y : req0_y;
        add_c <= w_gnt1 ? req1_c : req0_c;
      end
      case ({w_issue, w_emit})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp0_s     <= '0;
      rsp0_cout  <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_s     <= '0;
      rsp1_cout  <= 1'b0;
    end else begin
      rsp0_valid <= w_emit & ~r_tag_id[LAT];
      rsp1_valid <= w_emit &  r_tag_id[LAT];
      if (w_emit && !r_tag_id[LAT]) begin
        rsp0_s    <= add_s;
        rsp0_cout <= add_cout;
      end
      if (w_emit && r_tag_id[LAT]) begin
        rsp1_s    <= add_s;
        rsp1_cout <= add_cout;
      end
    end
  end
endmodule

// File: tb/tb_prefix_add_arbiter.sv
// Bench for prefix_add_arbiter: a behavioural LAT-deep adder model, directed stimulus,
// and a response scoreboard checked by an independent monitor.
module tb_prefix_add_arbiter;
  localparam int WIDTH = 32;
  localparam int LAT   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b1;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
  logic             req0_c = 1'b0, req1_c = 1'b0;
  logic [WIDTH-1:0] add_x, add_y, add_s;
  logic             add_c, add_cout;
  logic             rsp0_valid, rsp1_valid, rsp0_cout, rsp1_cout;
  logic [WIDTH-1:0] rsp0_s, rsp1_s;
  logic [$clog2(LAT+2)-1:0] inflight;
  logic             idle;

  prefix_add_arbiter #(.WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_x(req0_x), .req0_y(req0_y), .req0_c(req0_c),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_x(req1_x), .req1_y(req1_y), .req1_c(req1_c),
    .add_x(add_x), .add_y(add_y), .add_c(add_c),
    .add_s(add_s), .add_cout(add_cout),
    .rsp0_valid(rsp0_valid), .rsp0_s(rsp0_s), .rsp0_cout(rsp0_cout),
    .rsp1_valid(rsp1_valid), .rsp1_s(rsp1_s), .rsp1_cout(rsp1_cout),
    .inflight(inflight), .idle(idle)
  );

  always #5 clk = ~clk;

  // External adder: LAT register stages after the registered add_x/add_y/add_c.
  logic [WIDTH:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_c};
    for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
  end
  assign {add_cout, add_s} = apipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; logic [WIDTH-1:0] s; logic c; int at; } exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rsp0_valid || rsp1_valid) begin
          if (q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL rsp_unexpected: got pulse rsp0=%0b rsp1=%0b, expected none (cycle %0d)",
                     rsp0_valid, rsp1_valid, cyc);
          end else begin
            e = q.pop_front();
            chk("rsp_onehot", {63'd0, rsp0_valid & rsp1_valid}, 64'd0);
            chk("rsp_id", {63'd0, rsp1_valid}, e.id);
            chk("rsp_s", rsp1_valid ? rsp1_s : rsp0_s, e.s);
            chk("rsp_cout", rsp1_valid ? rsp1_cout : rsp0_cout, e.c);
            chk("rsp_cycle", cyc, e.at);
          end
        end else if (q.size() != 0 && q[0].at <= cyc) begin
          e = q.pop_front();
          n_chk++; n_fail++;
          $display("FAIL rsp_missing: got no pulse, expected id %0d s=%0h at cycle %0d", e.id, e.s, e.at);
        end
      end
    end
  end

  // One cycle of stimulus; g is the requester expected to be granted (-1 none).
  task automatic step(input logic e, input logic v0, input logic [WIDTH-1:0] x0, y0, input logic c0,
                      input logic v1, input logic [WIDTH-1:0] x1, y1, input logic c1,
                      input int g, input logic [WIDTH-1:0] es, input logic ec);
    exp_t t;
    @(negedge clk); #2;
    en = e;
    req0_valid = v0; req0_x = x0; req0_y = y0; req0_c = c0;
    req1_valid = v1; req1_x = x1; req1_y = y1; req1_c = c1;
    #1;
    chk("req0_ready", {63'd0, req0_ready}, (g == 0) ? 64'd1 : 64'd0);
    chk("req1_ready", {63'd0, req1_ready}, (g == 1) ? 64'd1 : 64'd0);
    if (g >= 0) begin
      t.id = g; t.s = es; t.c = ec; t.at = cyc + LAT + 2;
      q.push_back(t);
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    q.delete();
    #1;
    chk("rst_add_x", add_x, 0);
    chk("rst_add_y", add_y, 0);
    chk("rst_add_c", {63'd0, add_c}, 0);
    chk("rst_inflight", {61'd0, inflight}, 0);
    chk("rst_idle", {63'd0, idle}, 1);
    chk("rst_rsp_valid", {62'd0, rsp1_valid, rsp0_valid}, 0);
    chk("rst_rsp0_s", rsp0_s, 0);
    chk("rst_rsp1_s", rsp1_s, 0);
    @(negedge clk); #2;
    rst = 1'b0;
  endtask

  logic [WIDTH-1:0] sx [10];
  logic [WIDTH-1:0] sy [10];
  logic             sc [10];
  logic [WIDTH-1:0] ss [10];
  logic             sco [10];

  initial begin
    sx  = '{32'd100, 32'd7, 32'h80000000, 32'd1000, 32'h12345678, 32'd5, 32'hFFFFFFFE, 32'h0F0F0F0F, 32'd42, 32'hAAAAAAAA};
    sy  = '{32'd200, 32'd8, 32'h80000000, 32'd1,    32'h11111111, 32'd5, 32'd1,        32'hF0F0F0F0, 32'd0,  32'h55555555};
    sc  = '{1'b0,    1'b1,  1'b0,         1'b0,     1'b0,         1'b1,  1'b1,         1'b0,         1'b1,   1'b1};
    ss  = '{32'd300, 32'd16, 32'd0,       32'd1001, 32'h23456789, 32'd11, 32'd0,       32'hFFFFFFFF, 32'd43, 32'd0};
    sco = '{1'b0,    1'b0,  1'b1,         1'b0,     1'b0,         1'b0,  1'b1,         1'b0,         1'b0,   1'b1};

    do_reset();

    // Single operation from requester 0.
    step(1, 1, 32'd15, 32'd35, 1, 0, 0, 0, 0, 0, 32'd51, 0);
    idle_steps(7);

    // Contention straight out of reset: pointer starts at requester 0.
    do_reset();
    step(1, 1, 32'd24, 32'd43, 1, 1, 32'd53, 32'd70, 1, 0, 32'd68, 0);
    step(1, 0, 0, 0, 0,           1, 32'd53, 32'd70, 1, 1, 32'd124, 0);
    idle_steps(7);

    // Streaming with both valid: alternating grants, inflight saturating at LAT+1.
    for (int k = 0; k < 10; k++) begin
      step(1, 1, sx[k], sy[k], sc[k], 1, sx[k], sy[k], sc[k], k % 2, ss[k], sco[k]);
      chk("stream_inflight", {61'd0, inflight}, (k < 5) ? k : 5);
    end
    idle_steps(7);

    // Carry-out on wraparound.
    step(1, 0, 0, 0, 0, 1, 32'hFFFFFFFF, 32'd1, 0, 1, 32'd0, 1);
    step(1, 0, 0, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 32'hFFFFFFFF, 1);
    idle_steps(7);

    // Drain: three issues, then en low with requests still pending.
    step(1, 1, 32'd1, 32'd2, 0, 1, 32'd3, 32'd4, 0, 0, 32'd3, 0);
    step(1, 1, 32'd5, 32'd6, 1, 1, 32'd3, 32'd4, 0, 1, 32'd7, 0);
    step(1, 1, 32'd5, 32'd6, 1, 1, 32'd9, 32'd9, 0, 0, 32'd12, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 32'd8, 32'd8, 0, 1, 32'd9, 32'd9, 0, -1, 0, 0);
    chk("drain_idle", {63'd0, idle}, 1);
    chk("drain_inflight", {61'd0, inflight}, 0);

    // Reset while two operations are in flight: their results must never appear.
    step(1, 1, 32'd30, 32'd40, 0, 1, 32'd10, 32'd20, 0, 1, 32'd30, 0);
    step(1, 1, 32'd30, 32'd40, 0, 0, 0, 0, 0,             0, 32'd70, 0);
    idle_steps(1);
    do_reset();
    step(1, 1, 32'd2, 32'd3, 0, 1, 32'd7, 32'd7, 0, 0, 32'd5, 0);
    idle_steps(8);

    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d outstanding, expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
